// File: rtl/genaxis_pkt_gen.sv
// AXI-Stream packet generator: one command yields ceil(len/NB) beats of
// incrementing data starting at the seed, with a thermometer tkeep on the tail.
module genaxis_pkt_gen #(
  parameter int T_DATA_WIDTH = 64,
  parameter int LEN_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [LEN_W-1:0]          cmd_len,
  input  logic [T_DATA_WIDTH-1:0]   cmd_seed,
  output logic [T_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [T_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic [31:0]               pkt_cnt
);

  localparam int NB = T_DATA_WIDTH / 8;
  localparam int KW = $clog2(NB);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [T_DATA_WIDTH-1:0] data_q;
  logic [LEN_W-1:0]        rem_q;
  logic [KW:0]             tail_q;
  logic [LEN_W-1:0]        beats;
  logic [KW:0]             tail;
  logic [NB-1:0]           tail_keep;
  logic                    accept;
  logic                    xfer;
  logic                    last;

  assign accept = cmd_valid && cmd_ready;
  assign xfer   = m_axis_tvalid && m_axis_tready;
  assign last   = (state_q == SEND) && (rem_q == '0);

  // Shift-and-round-up form cannot overflow at cmd_len = all ones.
  assign beats = (cmd_len >> KW) + LEN_W'(|cmd_len[KW-1:0]);
  assign tail  = (cmd_len[KW-1:0] == '0) ? (KW+1)'(NB)
                                         : {1'b0, cmd_len[KW-1:0]};

  always_comb begin
    tail_keep = '0;
    for (int i = 0; i < NB; i++) begin
      tail_keep[i] = ((KW+1)'(i) < tail_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && (cmd_len != '0)) state_d = SEND;
      SEND: if (xfer && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      rem_q   <= '0;
      tail_q  <= '0;
      pkt_cnt <= '0;
    end else if (accept) begin
      data_q <= cmd_seed;
      rem_q  <= beats - LEN_W'(1);
      tail_q <= tail;
    end else if (xfer) begin
      data_q <= data_q + T_DATA_WIDTH'(1);
      rem_q  <= rem_q - LEN_W'(1);
      if (last) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  assign busy          = (state_q == SEND);
  assign cmd_ready     = (state_q == IDLE);
  assign m_axis_tvalid = busy;
  assign m_axis_tlast  = last;
  assign m_axis_tdata  = busy ? data_q : '0;
  assign m_axis_tkeep  = !busy ? '0 : (last ? tail_keep : '1);

endmodule

// File: tb/tb_genaxis_pkt_gen.sv
// Randomized and directed checks of genaxis_pkt_gen against a beat-level
// model derived from the packet length and seed.
module tb_genaxis_pkt_gen;

  localparam int W  = 64;
  localparam int LW = 16;

  logic          clk = 0;
  logic          reset_n = 0;
  logic          cmd_valid = 0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0]  cmd_seed = '0;
  logic [W-1:0]  m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 0;
  logic          m_axis_tlast;
  logic          busy;
  logic [31:0]   pkt_cnt;

  int            tests = 0;
  int            failed = 0;
  logic [31:0]   exp_cnt = 0;

  always #5 clk = ~clk;

  genaxis_pkt_gen #(.T_DATA_WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_keep(input int len, input int k);
    int beats;
    int r;
    beats = (len + 7) / 8;
    r = len - 8 * (beats - 1);
    if (k < beats - 1) return 8'hFF;
    return 8'((1 << r) - 1);
  endfunction

  task automatic issue(input int len, input logic [W-1:0] seed);
    check("cmd_ready_pre", W'(cmd_ready), W'(1));
    cmd_valid = 1;
    cmd_len   = LW'(len);
    cmd_seed  = seed;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  // Sends one packet and checks every observed cycle against the model.
  task automatic run_pkt(input int len, input logic [W-1:0] seed,
                         input bit rnd);
    int beats;
    int k;
    int cyc;
    logic [W-1:0] pdata;
    logic [7:0]   pkeep;
    logic         plast;
    logic         stalled;
    issue(len, seed);
    if (len == 0) begin
      repeat (3) begin
        check("zero_tvalid", W'(m_axis_tvalid), W'(0));
        check("zero_ready", W'(cmd_ready), W'(1));
        @(posedge clk); #1;
      end
      check("zero_cnt", W'(pkt_cnt), W'(exp_cnt));
      return;
    end
    beats = (len + 7) / 8;
    k = 0;
    cyc = 0;
    stalled = 0;
    while (k < beats && cyc < 8 * beats + 50) begin
      m_axis_tready = rnd ? 1'($urandom % 2) : 1'b1;
      check("tvalid", W'(m_axis_tvalid), W'(1));
      check("busy", W'(busy), W'(1));
      check("tdata", m_axis_tdata, seed + W'(k));
      check("tkeep", W'(m_axis_tkeep), W'(exp_keep(len, k)));
      check("tlast", W'(m_axis_tlast), W'(k == beats - 1));
      if (stalled) begin
        check("stall_data", m_axis_tdata, pdata);
        check("stall_keep", W'(m_axis_tkeep), W'(pkeep));
        check("stall_last", W'(m_axis_tlast), W'(plast));
      end
      pdata = m_axis_tdata;
      pkeep = m_axis_tkeep;
      plast = m_axis_tlast;
      stalled = m_axis_tvalid && !m_axis_tready;
      if (m_axis_tvalid && m_axis_tready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    m_axis_tready = 0;
    check("beats_done", W'(k), W'(beats));
    exp_cnt++;
    check("end_ready", W'(cmd_ready), W'(1));
    check("end_tvalid", W'(m_axis_tvalid), W'(0));
    check("end_tlast", W'(m_axis_tlast), W'(0));
    check("end_tdata", m_axis_tdata, W'(0));
    check("end_tkeep", W'(m_axis_tkeep), W'(0));
    check("pkt_cnt", W'(pkt_cnt), W'(exp_cnt));
  endtask

  initial begin
    #2;
    check("rst_tvalid", W'(m_axis_tvalid), W'(0));
    check("rst_tlast", W'(m_axis_tlast), W'(0));
    check("rst_tdata", m_axis_tdata, W'(0));
    check("rst_tkeep", W'(m_axis_tkeep), W'(0));
    check("rst_cnt", W'(pkt_cnt), W'(0));
    check("rst_busy", W'(busy), W'(0));
    #20 reset_n = 1;
    @(posedge clk); #1;
    check("rst_ready", W'(cmd_ready), W'(1));

    run_pkt(20, 64'h10, 0);
    run_pkt(16, 64'h1234, 0);
    run_pkt(1, 64'hABCD, 0);
    run_pkt(0, 64'h55, 0);
    run_pkt(24, 64'h77, 1);
    run_pkt(16, {W{1'b1}}, 0);
    run_pkt(65535, 64'hCAFE_0000, 0);

    for (int i = 0; i < 12; i++) begin
      run_pkt(int'($urandom_range(100, 0)),
              {$urandom, $urandom}, 1);
    end

    // Reset during beat 1 of a 4-beat packet.
    issue(32, 64'h900);
    m_axis_tready = 1;
    @(posedge clk); #1;
    m_axis_tready = 0;
    check("mid_beat1", m_axis_tdata, 64'h901);
    reset_n = 0;
    #1;
    check("mid_tvalid", W'(m_axis_tvalid), W'(0));
    check("mid_tlast", W'(m_axis_tlast), W'(0));
    check("mid_cnt", W'(pkt_cnt), W'(0));
    check("mid_busy", W'(busy), W'(0));
    exp_cnt = 0;
    #2 reset_n = 1;
    @(posedge clk); #1;
    check("post_ready", W'(cmd_ready), W'(1));
    check("post_tvalid", W'(m_axis_tvalid), W'(0));
    run_pkt(32, 64'h4000, 0);
    run_pkt(13, 64'h5000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
